// File: rtl/modexp_pkg.sv
// Shared definitions for the modular-exponentiation sequencer.
//   BITS_DEFAULT      default operand width
//   TIMEOUT_DEFAULT   default per-operation watchdog limit (MODEXP_TIMEOUT_EN builds)
//   state_e           top-level sequencer states
//   op_kind_e         kind of reduction currently requested (REDUCE/MUL/SQR)
//   shim_state_e      handshake shim states (IDLE/WAIT/RELEASE)
package modexp_pkg;

  localparam int BITS_DEFAULT    = 32;
  localparam int TIMEOUT_DEFAULT = 4096;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_REDUCE = 3'd2,
    ST_MUL    = 3'd3,
    ST_SQR    = 3'd4,
    ST_FIN    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    OP_REDUCE = 2'd0,
    OP_MUL    = 2'd1,
    OP_SQR    = 2'd2,
    OP_NONE   = 2'd3
  } op_kind_e;

  // SH_IDLE doubles as the ISSUE cycle: a request seen there loads the
  // operands and raises mod_start on the following cycle.
  typedef enum logic [1:0] {
    SH_IDLE    = 2'd0,
    SH_WAIT    = 2'd1,
    SH_RELEASE = 2'd2
  } shim_state_e;

  function automatic op_kind_e op_of_state(input state_e s);
    case (s)
      ST_REDUCE: return OP_REDUCE;
      ST_MUL:    return OP_MUL;
      ST_SQR:    return OP_SQR;
      default:   return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/modexp_ctrl_mod_req_if.sv
// mod_req_if: handshake shim between the exponent sequencer and the shared
// mod_module. A request accepted in IDLE (the ISSUE cycle) registers the
// operands and raises mod_start; WAIT holds everything until mod_done, captures
// the remainder and drops mod_start; RELEASE waits for mod_done to fall so a
// stale done can never complete the next operation.
// Optional watchdog: define MODEXP_TIMEOUT_EN to abort an operation after
// TIMEOUT_CYCLES cycles in WAIT (timeout_o pulses together with ack_o).
// Ports:
//   req_i/dividend_i/divisor_i   request from the sequencer (level)
//   ready_o                      shim idle, a new operation may begin
//   ack_o                        one-cycle completion pulse
//   timeout_o                    qualifies ack_o: operation was aborted
//   remainder_o                  captured remainder, valid from ack_o onwards
//   mod_start_o/mod_dividend_o/mod_divisor_o/mod_remainder_i/mod_done_i
//                                mod_module handshake
module mod_req_if
  import modexp_pkg::*;
#(
  parameter int BITS           = BITS_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic [2*BITS-1:0] dividend_i,
  input  logic [BITS-1:0]   divisor_i,
  output logic              ready_o,
  output logic              ack_o,
  output logic              timeout_o,
  output logic [BITS-1:0]   remainder_o,
  output logic              mod_start_o,
  output logic [2*BITS-1:0] mod_dividend_o,
  output logic [BITS-1:0]   mod_divisor_o,
  input  logic [BITS-1:0]   mod_remainder_i,
  input  logic              mod_done_i
);

  shim_state_e       state_q, state_d;
  logic              start_q, start_d;
  logic [2*BITS-1:0] dividend_q;
  logic [BITS-1:0]   divisor_q;
  logic [BITS-1:0]   remainder_q;
  logic              load;
  logic              capture;

`ifdef MODEXP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;
  logic             expired;

  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    load      = 1'b0;
    capture   = 1'b0;
    ack_o     = 1'b0;
    timeout_o = 1'b0;
`ifdef MODEXP_TIMEOUT_EN
    cnt_d     = cnt_q;
    abort_d   = abort_q;
`endif
    case (state_q)
      SH_IDLE: begin
        if (req_i) begin
          load    = 1'b1;
          start_d = 1'b1;
          state_d = SH_WAIT;
`ifdef MODEXP_TIMEOUT_EN
          cnt_d   = '0;
          abort_d = 1'b0;
`endif
        end
      end
      SH_WAIT: begin
        if (mod_done_i) begin
          capture = 1'b1;
          start_d = 1'b0;
          state_d = SH_RELEASE;
        end
`ifdef MODEXP_TIMEOUT_EN
        else if (expired) begin
          start_d   = 1'b0;
          timeout_o = 1'b1;
          ack_o     = 1'b1;
          abort_d   = 1'b1;
          state_d   = SH_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      SH_RELEASE: begin
        if (!mod_done_i) begin
          state_d = SH_IDLE;
          ack_o   = 1'b1;
`ifdef MODEXP_TIMEOUT_EN
          // An aborted operation was already acknowledged with the timeout.
          if (abort_q) ack_o = 1'b0;
`endif
        end
      end
      default: state_d = SH_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SH_IDLE;
      start_q     <= 1'b0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      remainder_q <= '0;
`ifdef MODEXP_TIMEOUT_EN
      cnt_q       <= '0;
      abort_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      if (load) begin
        dividend_q <= dividend_i;
        divisor_q  <= divisor_i;
      end
      if (capture) remainder_q <= mod_remainder_i;
`ifdef MODEXP_TIMEOUT_EN
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
`endif
    end
  end

  assign ready_o        = (state_q == SH_IDLE);
  assign remainder_o    = remainder_q;
  assign mod_start_o    = start_q;
  assign mod_dividend_o = dividend_q;
  assign mod_divisor_o  = divisor_q;

endmodule

// File: rtl/modexp_ctrl.sv
// modexp_ctrl: computes result = base^exponent mod modulus by right-to-left
// square-and-multiply. Products are formed here at full 2*BITS width; every
// reduction is delegated to an external mod_module through mod_req_if.
// Optional feature macro: MODEXP_TIMEOUT_EN (per-operation watchdog; a timeout
// finishes with error=1, result=0).
// Ports:
//   start/base/exponent/modulus   operands, captured when start is seen in IDLE
//   busy                          capture cycle until done
//   done                          one-cycle pulse, result/error valid
//   error                         modulus==0 or watchdog timeout
//   result                        final value, held until the next completion
//   mod_start/mod_dividend/mod_divisor/mod_remainder/mod_done
//                                 mod_module handshake
module modexp_ctrl
  import modexp_pkg::*;
#(
  parameter int BITS           = BITS_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BITS-1:0]   base,
  input  logic [BITS-1:0]   exponent,
  input  logic [BITS-1:0]   modulus,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [BITS-1:0]   result,
  output logic              mod_start,
  output logic [2*BITS-1:0] mod_dividend,
  output logic [BITS-1:0]   mod_divisor,
  input  logic [BITS-1:0]   mod_remainder,
  input  logic              mod_done
);

  state_e            state_q, state_d;
  logic [BITS-1:0]   base_q, base_d;
  logic [BITS-1:0]   e_q, e_d;
  logic [BITS-1:0]   n_q, n_d;
  logic [BITS-1:0]   acc_q, acc_d;
  logic [BITS-1:0]   b_q, b_d;
  logic [BITS-1:0]   result_q, result_d;
  logic              err_q, err_d;

  logic              req;
  logic              ack;
  logic              timeout;
  logic              ready;
  logic [BITS-1:0]   rem;
  op_kind_e          op_kind;
  logic [BITS-1:0]   mul_a;
  logic [2*BITS-1:0] product;
  logic [2*BITS-1:0] dividend;
  logic [BITS-1:0]   e_shift;

  // One shared multiplier: MUL forms acc*b, SQR forms b*b. Both operands are
  // already reduced below n, so the 2*BITS product is exact.
  assign op_kind = op_of_state(state_q);
  assign mul_a   = (op_kind == OP_MUL) ? acc_q : b_q;
  assign product = {{BITS{1'b0}}, mul_a} * {{BITS{1'b0}}, b_q};
  assign e_shift = e_q >> 1;

  always_comb begin
    dividend = product;
    if (op_kind == OP_REDUCE) dividend = {{BITS{1'b0}}, base_q};
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    e_d      = e_q;
    n_d      = n_q;
    acc_d    = acc_q;
    b_d      = b_q;
    result_d = result_q;
    err_d    = err_q;
    req      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // ready is low only while the shim drains a timed-out operation.
        if (start && ready) begin
          base_d  = base;
          e_d     = exponent;
          n_d     = modulus;
          err_d   = 1'b0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (n_q == '0) begin
          err_d    = 1'b1;
          result_d = '0;
          state_d  = ST_FIN;
        end else if (n_q == BITS'(1)) begin
          result_d = '0;
          state_d  = ST_FIN;
        end else begin
          acc_d   = BITS'(1);
          state_d = ST_REDUCE;
        end
      end
      ST_REDUCE, ST_MUL, ST_SQR: begin
        req = 1'b1;
        if (ack) begin
          if (timeout) begin
            err_d    = 1'b1;
            result_d = '0;
            state_d  = ST_FIN;
          end else begin
            case (state_q)
              ST_REDUCE: begin
                b_d = rem;
                if (e_q == '0) begin
                  result_d = acc_q;
                  state_d  = ST_FIN;
                end else if (e_q[0]) begin
                  state_d = ST_MUL;
                end else begin
                  // e is non-zero with a clear LSB, so e>>1 is still non-zero.
                  e_d     = e_shift;
                  state_d = ST_SQR;
                end
              end
              ST_MUL: begin
                acc_d = rem;
                e_d   = e_shift;
                if (e_shift == '0) begin
                  result_d = rem;
                  state_d  = ST_FIN;
                end else begin
                  state_d = ST_SQR;
                end
              end
              ST_SQR: begin
                // SQR is only entered with e non-zero after the shift, so the
                // walk always continues with another MUL or SQR.
                b_d = rem;
                if (e_q[0]) begin
                  state_d = ST_MUL;
                end else begin
                  e_d     = e_shift;
                  state_d = ST_SQR;
                end
              end
              default: state_d = ST_IDLE;
            endcase
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, so result and the mod_module
  // operands read as zero immediately after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      e_q      <= '0;
      n_q      <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      e_q      <= e_d;
      n_q      <= n_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  mod_req_if #(
    .BITS           (BITS),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_req (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_i           (req),
    .dividend_i      (dividend),
    .divisor_i       (n_q),
    .ready_o         (ready),
    .ack_o           (ack),
    .timeout_o       (timeout),
    .remainder_o     (rem),
    .mod_start_o     (mod_start),
    .mod_dividend_o  (mod_dividend),
    .mod_divisor_o   (mod_divisor),
    .mod_remainder_i (mod_remainder),
    .mod_done_i      (mod_done)
  );

  assign busy   = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done   = (state_q == ST_FIN);
  assign error  = err_q;
  assign result = result_q;

endmodule
